axi4_ram_writer: RTL and testbench
==================================

AXI4_RAM_WRITER -- requirements
Module: axi4_ram_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written; must be 64-byte aligned.
REQ-002 SHALL have parameter BURST_COUNT, default 16: number of bursts per operation; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start_write, input, 1 bit: one-cycle strobe that starts an operation (from the AXI control block).
REQ-006 SHALL have port clear, input, 1 bit: sampled with start_write; 1 = write zeros, 0 = write the address pattern.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle strobe when an operation ends.
REQ-009 SHALL have port error, output, 1 bit: high when any BRESP of the last operation was non-OKAY.
REQ-010 SHALL have AW channel ports M_AXI_AWADDR (out, 32), M_AXI_AWLEN (out, 8), M_AXI_AWSIZE (out, 3), M_AXI_AWBURST (out, 2), M_AXI_AWVALID (out, 1) and M_AXI_AWREADY (in, 1).
REQ-011 SHALL have W channel ports M_AXI_WDATA (out, 32), M_AXI_WSTRB (out, 4), M_AXI_WLAST (out, 1), M_AXI_WVALID (out, 1) and M_AXI_WREADY (in, 1).
REQ-012 SHALL have B channel ports M_AXI_BRESP (in, 2), M_AXI_BVALID (in, 1) and M_AXI_BREADY (out, 1).

Function
REQ-013 SHALL drive the constant outputs AWLEN=15 (16 beats), AWSIZE=3'b010, AWBURST=2'b01 (INCR) and WSTRB=4'hF.
REQ-014 SHALL use the state machine IDLE -> AW -> W -> B; from B it SHALL go to AW when bursts remain, else to IDLE.
REQ-015 In IDLE, start_write=1 SHALL latch clear, set busy and enter AW; AWVALID SHALL be high on the next cycle.
REQ-016 SHALL ignore start_write while busy=1; the operation in progress is unaffected.
REQ-017 In AW, AWADDR SHALL equal BASE_ADDR + 64*burst_index, held stable with AWVALID until AWREADY; it SHALL then enter W.
REQ-018 In W, WVALID SHALL stay high, with WDATA and WLAST held stable while WREADY=0; each beat SHALL advance on WVALID&WREADY.
REQ-019 WDATA SHALL be 0 when clear was latched as 1, else the byte address of that word (AWADDR + 4*beat).
REQ-020 WLAST SHALL be high only on beat 15; after the beat-15 handshake the block SHALL enter B.
REQ-021 W SHALL never be asserted before its burst's AW handshake completes, and only one burst SHALL be outstanding.
REQ-022 In B, BREADY SHALL be high; a BVALID&BREADY handshake with BRESP!=2'b00 SHALL set error.
REQ-023 On the final burst's B handshake, the next cycle SHALL have done=1 for exactly one cycle and busy=0.
REQ-024 error SHALL clear when a new operation is accepted and SHALL hold its value from done until then.
REQ-025 The burst counter SHALL be 16 bits wide, with no wrap within an operation; address arithmetic SHALL be 32-bit modulo.

Reset
REQ-026 resetn=0 SHALL asynchronously force state IDLE, clear all counters, and drive AWVALID, WVALID, BREADY, busy, done and error to 0; AWADDR, WDATA and WLAST SHALL be 0.
REQ-027 Reset during an operation SHALL abandon it without asserting done; the first start_write after release SHALL start a fresh operation at BASE_ADDR.

Configuration
REQ-028 Macro AXI4_RAM_WRITER_ABORT_EN SHALL control abort-on-error behaviour.
REQ-029 With AXI4_RAM_WRITER_ABORT_EN defined, a non-OKAY BRESP SHALL end the operation after that handshake: remaining bursts are skipped, done pulses, error=1.
REQ-030 With AXI4_RAM_WRITER_ABORT_EN undefined, all BURST_COUNT bursts SHALL always be issued, and error SHALL only be reported.

Verification
REQ-031 start_write=1, clear=0, BURST_COUNT=2, slave always ready -> AWADDR 0x00 then 0x40; WDATA 0x00..0x3C and 0x40..0x7C; WLAST on beats 15 and 31; one done pulse; error=0.
REQ-032 start_write=1, clear=1, randomized AWREADY/WREADY backpressure -> all 32 WDATA=0, address/data stable while stalled, exactly 32 W handshakes.
REQ-033 Second start_write pulse in the middle of the W phase -> ignored; total bursts remain BURST_COUNT; one done.
REQ-034 BRESP=2'b10 on burst 0 of 2 -> with ABORT_EN: one burst, done, error=1; without: two bursts, done, error=1; next start clears error.
REQ-035 resetn low during beat 7 -> WVALID/busy drop immediately, no done; the restart writes from BASE_ADDR correctly.

Source files
------------

// File: rtl/axi4_ram_writer.sv
// axi4_ram_writer: fills a RAM region over AXI4 with BURST_COUNT 16-beat INCR
// bursts, writing either zeros or each word's own byte address.
// Build option: define AXI4_RAM_WRITER_ABORT_EN to end an operation early on
// the first non-OKAY write response; otherwise errors are only reported.
module axi4_ram_writer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned BURST_COUNT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_write,
    input  logic        clear,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] M_AXI_AWADDR,
    output logic [7:0]  M_AXI_AWLEN,
    output logic [2:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WLAST,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY
);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    localparam logic [15:0] LAST_BURST = 16'(BURST_COUNT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_clear;
    logic [15:0] r_burst;
    logic [3:0]  r_beat;
    logic [31:0] r_addr;
    logic        r_done;
    logic        r_error;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_bad_resp;
    logic        w_abort;
    logic        w_op_end;

    assign w_aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs     = M_AXI_WVALID & M_AXI_WREADY;
    assign w_b_hs     = M_AXI_BVALID & M_AXI_BREADY;
    assign w_bad_resp = (M_AXI_BRESP != 2'b00);

`ifdef AXI4_RAM_WRITER_ABORT_EN
    assign w_abort = w_bad_resp;
`else
    assign w_abort = 1'b0;
`endif

    // The operation ends after the last burst's response, or on an error when aborting.
    assign w_op_end = (r_burst == LAST_BURST) | w_abort;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and channel valid/ready decode
    always_comb begin
        w_next_state  = r_state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_write) w_next_state = S_AW;
            end
            S_AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) w_next_state = S_W;
            end
            S_W: begin
                M_AXI_WVALID = 1'b1;
                if (M_AXI_WREADY && r_beat == 4'hF) w_next_state = S_B;
            end
            S_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) w_next_state = w_op_end ? S_IDLE : S_AW;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Burst/beat counters, burst address, latched mode, done strobe and error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clear <= 1'b0;
            r_burst <= '0;
            r_beat  <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_write) begin
                        r_clear <= clear;
                        r_burst <= '0;
                        r_beat  <= '0;
                        r_addr  <= BASE_ADDR;
                        r_error <= 1'b0;
                    end
                end
                S_W: begin
                    // 4-bit beat counter rolls back to 0 after beat 15 for the next burst
                    if (w_w_hs) r_beat <= r_beat + 4'd1;
                end
                S_B: begin
                    if (w_b_hs) begin
                        if (w_bad_resp) r_error <= 1'b1;
                        if (w_op_end) begin
                            r_done <= 1'b1;
                        end else begin
                            r_burst <= r_burst + 16'd1;
                            r_addr  <= r_addr + 32'd64;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWLEN   = 8'd15;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WDATA   = r_clear ? '0 : (r_addr + {26'd0, r_beat, 2'b00});
    assign M_AXI_WLAST   = (r_state == S_W) && (r_beat == 4'hF);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign error         = r_error;

endmodule

// File: tb/tb_axi4_ram_writer.sv
// Self-checking bench for axi4_ram_writer: randomized AXI slave responder,
// table of operations checked against an address/data reference model.
module tb_axi4_ram_writer;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          BC   = 2;

    logic        clk;
    logic        resetn;
    logic        start_write;
    logic        clear;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    axi4_ram_writer #(.BASE_ADDR(BASE), .BURST_COUNT(BC)) dut (
        .clk(clk), .resetn(resetn), .start_write(start_write), .clear(clear),
        .busy(busy), .done(done), .error(error),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         clr;
        int         aw_pct;
        int         w_pct;
        int         bad_idx;
        logic [1:0] bad_resp;
        bit         second;
        int         exp_bursts;
        bit         exp_err;
    } vec_t;

    // Slave/monitor state
    int          aw_pct_c = 100;
    int          w_pct_c  = 100;
    int          bad_idx_c = -1;
    logic [1:0]  bad_resp_c = 2'b00;
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    bit          wl_q[$];
    int          aw_cnt, b_cnt, done_cnt, stall_viol, order_viol, done_viol;
    int          mon_cyc, last_b_cyc;
    bit          b_pend, b_hs;
    bit          prev_aw_stall, prev_w_stall;
    logic [31:0] prev_awaddr, prev_wdata;
    logic        prev_wlast;

    task automatic clear_mon();
        aw_q.delete(); w_q.delete(); wl_q.delete();
        aw_cnt = 0; b_cnt = 0; done_cnt = 0;
        stall_viol = 0; order_viol = 0; done_viol = 0;
    endtask

    // AXI slave: random ready at each falling edge, then record what the next rising edge accepts
    initial begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        b_pend = 0; b_hs = 0; prev_aw_stall = 0; prev_w_stall = 0;
        mon_cyc = 0; last_b_cyc = -10;
        clear_mon();
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!resetn) begin
                M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
                b_pend = 0; b_hs = 0; prev_aw_stall = 0; prev_w_stall = 0;
            end else begin
                M_AXI_AWREADY = ($urandom_range(99) < aw_pct_c);
                M_AXI_WREADY  = ($urandom_range(99) < w_pct_c);
                if (b_hs) begin M_AXI_BVALID = 1'b0; b_hs = 0; end
                if (b_pend) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = (b_cnt == bad_idx_c) ? bad_resp_c : 2'b00;
                    b_pend = 0;
                end
                #1;
                if (prev_aw_stall && (!M_AXI_AWVALID || M_AXI_AWADDR !== prev_awaddr)) stall_viol++;
                if (prev_w_stall && (!M_AXI_WVALID || M_AXI_WDATA !== prev_wdata || M_AXI_WLAST !== prev_wlast))
                    stall_viol++;
                if (M_AXI_AWVALID && aw_cnt != b_cnt) order_viol++;
                if (M_AXI_WVALID && aw_cnt != b_cnt + 1) order_viol++;
                if (done) begin
                    done_cnt++;
                    if (busy || mon_cyc != last_b_cyc + 1) done_viol++;
                end
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_q.push_back(M_AXI_AWADDR); aw_cnt++; end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    w_q.push_back(M_AXI_WDATA);
                    wl_q.push_back(M_AXI_WLAST);
                    if (M_AXI_WLAST) b_pend = 1;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) begin b_cnt++; b_hs = 1; last_b_cyc = mon_cyc; end
                prev_aw_stall = M_AXI_AWVALID && !M_AXI_AWREADY;
                prev_w_stall  = M_AXI_WVALID && !M_AXI_WREADY;
                prev_awaddr   = M_AXI_AWADDR;
                prev_wdata    = M_AXI_WDATA;
                prev_wlast    = M_AXI_WLAST;
            end
        end
    end

    task automatic start_op(input bit clr);
        @(negedge clk); #2;
        start_write = 1'b1; clear = clr;
        @(negedge clk); #2;
        start_write = 1'b0; clear = ~clr;
    endtask

    task automatic run_op(input vec_t v);
        int  cyc;
        bit  pulsed;
        logic [31:0] exp_d;
        clear_mon();
        aw_pct_c = v.aw_pct; w_pct_c = v.w_pct;
        bad_idx_c = v.bad_idx; bad_resp_c = v.bad_resp;
        start_op(v.clr);
        chk("busy_after_start", busy, 1);
        chk("awvalid_after_start", M_AXI_AWVALID, 1);
        chk("error_cleared_on_start", error, 0);
        cyc = 0; pulsed = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(negedge clk); #2;
            cyc++;
            start_write = 1'b0;
            if (v.second && !pulsed && w_q.size() >= 5) begin
                start_write = 1'b1; clear = ~v.clr; pulsed = 1;
            end
        end
        start_write = 1'b0;
        chk("done_within_budget", (done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        #2;
        chk("done_pulses", done_cnt, 1);
        chk("done_timing", done_viol, 0);
        chk("busy_after_done", busy, 0);
        chk("error_held", error, v.exp_err);
        chk("aw_bursts", aw_q.size(), v.exp_bursts);
        chk("w_beats", w_q.size(), 16 * v.exp_bursts);
        chk("b_responses", b_cnt, v.exp_bursts);
        chk("stall_stability", stall_viol, 0);
        chk("channel_order", order_viol, 0);
        for (int i = 0; i < aw_q.size() && i < v.exp_bursts; i++)
            chk("awaddr", aw_q[i], BASE + 32'(64 * i));
        for (int k = 0; k < w_q.size() && k < 16 * v.exp_bursts; k++) begin
            exp_d = v.clr ? 32'd0 : BASE + 32'(64 * (k / 16)) + 32'(4 * (k % 16));
            chk("wdata", w_q[k], exp_d);
            chk("wlast", wl_q[k], (k % 16) == 15);
        end
    endtask

    // Expected bursts for a failing response at index bad (bad >= BC means no failure)
    function automatic int exp_bursts_for(input int bad);
`ifdef AXI4_RAM_WRITER_ABORT_EN
        return (bad >= 0 && bad < BC) ? bad + 1 : BC;
`else
        return BC;
`endif
    endfunction

    vec_t tbl [0:10];

    initial begin
        int cyc;
        tbl[0] = '{0, 100, 100, -1, 2'b00, 0, BC, 0};
        tbl[1] = '{1,  40,  40, -1, 2'b00, 0, BC, 0};
        tbl[2] = '{0,  60,  50, -1, 2'b00, 1, BC, 0};
        tbl[3] = '{0, 100, 100,  0, 2'b10, 0, exp_bursts_for(0), 1};
        tbl[4] = '{1,  70,  70, -1, 2'b00, 0, BC, 0};
        tbl[5] = '{0,  50,  50,  1, 2'b11, 0, exp_bursts_for(1), 1};
        tbl[6] = '{0,  30,  80, -1, 2'b00, 0, BC, 0};
        for (int i = 7; i <= 10; i++) begin
            int bad;
            bad = int'($urandom_range(0, 2));
            tbl[i] = '{bit'($urandom_range(0, 1)), int'($urandom_range(20, 100)),
                       int'($urandom_range(20, 100)), bad, 2'b10, bit'($urandom_range(0, 1)),
                       exp_bursts_for(bad), (bad < BC)};
        end

        resetn = 1'b0; start_write = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_awaddr", M_AXI_AWADDR, 0);
        chk("rst_wdata", M_AXI_WDATA, 0);
        chk("rst_wlast", M_AXI_WLAST, 0);
        chk("const_awlen", M_AXI_AWLEN, 8'd15);
        chk("const_awsize", M_AXI_AWSIZE, 3'b010);
        chk("const_awburst", M_AXI_AWBURST, 2'b01);
        chk("const_wstrb", M_AXI_WSTRB, 4'hF);
        resetn = 1'b1;

        for (int i = 0; i <= 10; i++) run_op(tbl[i]);

        // Reset in the middle of the W phase of burst 0
        clear_mon();
        aw_pct_c = 100; w_pct_c = 100; bad_idx_c = -1;
        start_op(1'b0);
        cyc = 0;
        while (w_q.size() < 7 && cyc < 200) begin @(negedge clk); #2; cyc++; end
        chk("reached_beat7", (w_q.size() >= 7), 1);
        @(posedge clk); #2;
        chk("wvalid_before_reset", M_AXI_WVALID, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_wvalid", M_AXI_WVALID, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_awvalid", M_AXI_AWVALID, 0);
        chk("midrst_wdata", M_AXI_WDATA, 0);
        chk("midrst_awaddr", M_AXI_AWADDR, 0);
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("no_done_after_abandon", done_cnt, 0);
        chk("idle_after_abandon", busy, 0);
        run_op(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
